// File: rtl/rename_regfile_mp_pkg.sv
// Shared constants, types and helpers for the rename register file.
package rename_regfile_mp_pkg;

  localparam int REG_IDX_W         = 5;
  localparam int NUM_REGS          = 32;
  localparam int DEF_XLEN          = 32;
  localparam int DEF_ROB_WIDTH_BIT = 4;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // Resolution outcome for one source operand, in priority order.
  typedef enum logic [2:0] {
    SrcZero,
    SrcGroup,
    SrcCommit,
    SrcRob,
    SrcWait,
    SrcReg
  } src_case_e;

  function automatic logic [5:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt = cnt + 6'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/rename_regfile_mp_rf_src_resolve.sv
// Single-source priority resolver: zero reg, same-group rename, commit, ROB result, tag, reg value.
module rename_regfile_mp_rf_src_resolve
  import rename_regfile_mp_pkg::*;
#(
  parameter int COMMIT_W      = 2,
  parameter int ROB_WIDTH_BIT = DEF_ROB_WIDTH_BIT,
  parameter int XLEN          = DEF_XLEN
) (
  input  reg_idx_t                        i_rs,
  input  logic                            i_grp_hit,
  input  logic [ROB_WIDTH_BIT-1:0]        i_grp_tag,
  input  logic                            i_busy,
  input  logic [ROB_WIDTH_BIT-1:0]        i_qi,
  input  logic [XLEN-1:0]                 i_reg_val,
  input  logic [COMMIT_W-1:0]             i_cmt_valid,
  input  logic [ROB_WIDTH_BIT*COMMIT_W-1:0] i_cmt_rob,
  input  logic [XLEN*COMMIT_W-1:0]        i_cmt_val,
  input  logic                            i_q_ready,
  input  logic [XLEN-1:0]                 i_q_val,
  output logic [XLEN-1:0]                 o_val,
  output logic                            o_dep,
  output logic [ROB_WIDTH_BIT-1:0]        o_tag
);

  logic            w_cmt_hit;
  logic [XLEN-1:0] w_cmt_val;
  src_case_e       w_case;

  // Later commit slots are younger, so the last match wins.
  always_comb begin
    w_cmt_hit = 1'b0;
    w_cmt_val = '0;
    for (int j = 0; j < COMMIT_W; j++) begin
      if (i_cmt_valid[j] && (i_cmt_rob[j*ROB_WIDTH_BIT +: ROB_WIDTH_BIT] == i_qi)) begin
        w_cmt_hit = 1'b1;
        w_cmt_val = i_cmt_val[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    if (i_rs == '0)                w_case = SrcZero;
    else if (i_grp_hit)            w_case = SrcGroup;
    else if (i_busy && w_cmt_hit)  w_case = SrcCommit;
    else if (i_busy && i_q_ready)  w_case = SrcRob;
    else if (i_busy)               w_case = SrcWait;
    else                           w_case = SrcReg;
  end

  always_comb begin
    o_val = '0;
    o_dep = 1'b0;
    o_tag = '0;
    unique case (w_case)
      SrcZero:   ;
      SrcGroup:  begin o_dep = 1'b1; o_tag = i_grp_tag; end
      SrcCommit: o_val = w_cmt_val;
      SrcRob:    o_val = i_q_val;
      SrcWait:   begin o_dep = 1'b1; o_tag = i_qi; end
      SrcReg:    o_val = i_reg_val;
      default:   ;
    endcase
  end

endmodule

// File: rtl/rename_regfile_mp.sv
// Multi-port architectural register file with rename-tag tracking, issue/commit bypass.
module rename_regfile_mp
  import rename_regfile_mp_pkg::*;
#(
  parameter int ISSUE_W       = 2,
  parameter int COMMIT_W      = 2,
  parameter int ROB_WIDTH_BIT = DEF_ROB_WIDTH_BIT,
  parameter int XLEN          = DEF_XLEN
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              rdy_in,
  input  logic                              clear_flag,
  input  logic [ISSUE_W-1:0]                iss_valid,
  input  logic [REG_IDX_W*ISSUE_W-1:0]      iss_rs1,
  input  logic [REG_IDX_W*ISSUE_W-1:0]      iss_rs2,
  input  logic [REG_IDX_W*ISSUE_W-1:0]      iss_rd,
  input  logic [ROB_WIDTH_BIT*ISSUE_W-1:0]  iss_rob,
  output logic [XLEN*ISSUE_W-1:0]           src1_val,
  output logic [ISSUE_W-1:0]                src1_dep,
  output logic [ROB_WIDTH_BIT*ISSUE_W-1:0]  src1_rob,
  output logic [XLEN*ISSUE_W-1:0]           src2_val,
  output logic [ISSUE_W-1:0]                src2_dep,
  output logic [ROB_WIDTH_BIT*ISSUE_W-1:0]  src2_rob,
  output logic [ROB_WIDTH_BIT*ISSUE_W-1:0]  q1_id,
  input  logic [ISSUE_W-1:0]                q1_ready,
  input  logic [XLEN*ISSUE_W-1:0]           q1_val,
  output logic [ROB_WIDTH_BIT*ISSUE_W-1:0]  q2_id,
  input  logic [ISSUE_W-1:0]                q2_ready,
  input  logic [XLEN*ISSUE_W-1:0]           q2_val,
  input  logic [COMMIT_W-1:0]               cmt_valid,
  input  logic [REG_IDX_W*COMMIT_W-1:0]     cmt_rd,
  input  logic [ROB_WIDTH_BIT*COMMIT_W-1:0] cmt_rob,
  input  logic [XLEN*COMMIT_W-1:0]          cmt_val,
  output logic [5:0]                        busy_cnt
);

  localparam int NSRC = 2 * ISSUE_W;
  localparam int RB   = ROB_WIDTH_BIT;

  logic [XLEN-1:0]     r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [RB-1:0]       r_qi [NUM_REGS];
  logic [5:0]          r_busy_cnt;

  logic [XLEN-1:0]     w_regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] w_busy_d;
  logic [RB-1:0]       w_qi_d [NUM_REGS];
  logic [NUM_REGS-1:0] w_rename_hit;

  // Sources 0..ISSUE_W-1 are rs1 of each slot, ISSUE_W..NSRC-1 are rs2.
  reg_idx_t            w_rs [NSRC];
  logic                w_grp_hit [NSRC];
  logic [RB-1:0]       w_grp_tag [NSRC];
  logic                w_q_ready [NSRC];
  logic [XLEN-1:0]     w_q_val [NSRC];
  logic [XLEN-1:0]     w_res_val [NSRC];
  logic                w_res_dep [NSRC];
  logic [RB-1:0]       w_res_tag [NSRC];

  always_comb begin
    for (int k = 0; k < ISSUE_W; k++) begin
      w_rs[k]              = iss_rs1[k*REG_IDX_W +: REG_IDX_W];
      w_rs[ISSUE_W+k]      = iss_rs2[k*REG_IDX_W +: REG_IDX_W];
      w_q_ready[k]         = q1_ready[k];
      w_q_ready[ISSUE_W+k] = q2_ready[k];
      w_q_val[k]           = q1_val[k*XLEN +: XLEN];
      w_q_val[ISSUE_W+k]   = q2_val[k*XLEN +: XLEN];
    end
  end

  // Only older slots of the same group forward a rename; the youngest of them wins.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      w_grp_hit[i] = 1'b0;
      w_grp_tag[i] = '0;
      for (int j = 0; j < ISSUE_W; j++) begin
        if ((j < (i % ISSUE_W)) && iss_valid[j] &&
            (iss_rd[j*REG_IDX_W +: REG_IDX_W] == w_rs[i])) begin
          w_grp_hit[i] = 1'b1;
          w_grp_tag[i] = iss_rob[j*RB +: RB];
        end
      end
    end
  end

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    rename_regfile_mp_rf_src_resolve #(
      .COMMIT_W      (COMMIT_W),
      .ROB_WIDTH_BIT (ROB_WIDTH_BIT),
      .XLEN          (XLEN)
    ) u_resolve (
      .i_rs        (w_rs[i]),
      .i_grp_hit   (w_grp_hit[i]),
      .i_grp_tag   (w_grp_tag[i]),
      .i_busy      (r_busy[w_rs[i]]),
      .i_qi        (r_qi[w_rs[i]]),
      .i_reg_val   (r_regs[w_rs[i]]),
      .i_cmt_valid (cmt_valid),
      .i_cmt_rob   (cmt_rob),
      .i_cmt_val   (cmt_val),
      .i_q_ready   (w_q_ready[i]),
      .i_q_val     (w_q_val[i]),
      .o_val       (w_res_val[i]),
      .o_dep       (w_res_dep[i]),
      .o_tag       (w_res_tag[i])
    );
  end

  always_comb begin
    for (int k = 0; k < ISSUE_W; k++) begin
      src1_val[k*XLEN +: XLEN] = w_res_val[k];
      src2_val[k*XLEN +: XLEN] = w_res_val[ISSUE_W+k];
      src1_dep[k]              = w_res_dep[k];
      src2_dep[k]              = w_res_dep[ISSUE_W+k];
      src1_rob[k*RB +: RB]     = w_res_tag[k];
      src2_rob[k*RB +: RB]     = w_res_tag[ISSUE_W+k];
      q1_id[k*RB +: RB]        = r_qi[w_rs[k]];
      q2_id[k*RB +: RB]        = r_qi[w_rs[ISSUE_W+k]];
    end
  end

  always_comb begin
    w_rename_hit = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      if (iss_valid[k]) w_rename_hit[iss_rd[k*REG_IDX_W +: REG_IDX_W]] = 1'b1;
    end
  end

  // Commits first, then renames, so a same-cycle rename overrides the tag release.
  always_comb begin
    w_regs_d = r_regs;
    w_busy_d = r_busy;
    w_qi_d   = r_qi;
    for (int j = 0; j < COMMIT_W; j++) begin
      if (cmt_valid[j] && (cmt_rd[j*REG_IDX_W +: REG_IDX_W] != '0)) begin
        w_regs_d[cmt_rd[j*REG_IDX_W +: REG_IDX_W]] = cmt_val[j*XLEN +: XLEN];
        if (r_busy[cmt_rd[j*REG_IDX_W +: REG_IDX_W]] &&
            (r_qi[cmt_rd[j*REG_IDX_W +: REG_IDX_W]] == cmt_rob[j*RB +: RB]) &&
            !w_rename_hit[cmt_rd[j*REG_IDX_W +: REG_IDX_W]]) begin
          w_busy_d[cmt_rd[j*REG_IDX_W +: REG_IDX_W]] = 1'b0;
          w_qi_d[cmt_rd[j*REG_IDX_W +: REG_IDX_W]]   = '0;
        end
      end
    end
    if (clear_flag) begin
      w_busy_d = '0;
      for (int i = 0; i < NUM_REGS; i++) w_qi_d[i] = '0;
    end else begin
      for (int k = 0; k < ISSUE_W; k++) begin
        if (iss_valid[k] && (iss_rd[k*REG_IDX_W +: REG_IDX_W] != '0)) begin
          w_busy_d[iss_rd[k*REG_IDX_W +: REG_IDX_W]] = 1'b1;
          w_qi_d[iss_rd[k*REG_IDX_W +: REG_IDX_W]]   = iss_rob[k*RB +: RB];
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
        r_qi[i]   <= '0;
      end
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= w_regs_d[i];
        r_qi[i]   <= w_qi_d[i];
      end
      r_busy     <= w_busy_d;
      r_busy_cnt <= popcount(w_busy_d);
    end
  end

  assign busy_cnt = r_busy_cnt;

endmodule

// File: tb/tb_rename_regfile_mp.sv
// Directed self-checking bench for rename_regfile_mp (ISSUE_W=2, COMMIT_W=2, RB=4, XLEN=32).
module tb_rename_regfile_mp;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_flag;
  logic [1:0]  iss_valid;
  logic [9:0]  iss_rs1, iss_rs2, iss_rd;
  logic [7:0]  iss_rob;
  logic [63:0] src1_val, src2_val;
  logic [1:0]  src1_dep, src2_dep;
  logic [7:0]  src1_rob, src2_rob, q1_id, q2_id;
  logic [1:0]  q1_ready, q2_ready;
  logic [63:0] q1_val, q2_val;
  logic [1:0]  cmt_valid;
  logic [9:0]  cmt_rd;
  logic [7:0]  cmt_rob;
  logic [63:0] cmt_val;
  logic [5:0]  busy_cnt;
  int          checks = 0;
  int          errors = 0;

  rename_regfile_mp dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_flag(clear_flag),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_rob(iss_rob), .src1_val(src1_val), .src1_dep(src1_dep), .src1_rob(src1_rob),
    .src2_val(src2_val), .src2_dep(src2_dep), .src2_rob(src2_rob), .q1_id(q1_id),
    .q1_ready(q1_ready), .q1_val(q1_val), .q2_id(q2_id), .q2_ready(q2_ready),
    .q2_val(q2_val), .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_rob(cmt_rob),
    .cmt_val(cmt_val), .busy_cnt(busy_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic idle();
    iss_valid = '0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0; iss_rob = '0;
    q1_ready = '0; q1_val = '0; q2_ready = '0; q2_val = '0;
    cmt_valid = '0; cmt_rd = '0; cmt_rob = '0; cmt_val = '0;
    clear_flag = 1'b0;
  endtask

  task automatic set_iss(input int k, input logic v, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic [3:0] rob);
    iss_valid[k] = v; iss_rs1[k*5 +: 5] = rs1; iss_rs2[k*5 +: 5] = rs2;
    iss_rd[k*5 +: 5] = rd; iss_rob[k*4 +: 4] = rob;
  endtask

  task automatic set_cmt(input int j, input logic v, input logic [4:0] rd,
                         input logic [3:0] rob, input logic [31:0] val);
    cmt_valid[j] = v; cmt_rd[j*5 +: 5] = rd; cmt_rob[j*4 +: 4] = rob;
    cmt_val[j*32 +: 32] = val;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    idle();
    set_iss(0, 1'b0, 5'd5, 5'd0, 5'd0, 4'd0);
    #1;
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL reset_busy_cnt got %0d want 0", busy_cnt); end
    checks++; if (src1_dep[0] !== 1'b0) begin errors++; $display("FAIL reset_dep got %b want 0", src1_dep[0]); end
    checks++; if (src1_val[31:0] !== 32'h0) begin errors++; $display("FAIL reset_val got %h want 0", src1_val[31:0]); end
  endtask

  task automatic test_group_rename();
    idle();
    set_iss(0, 1'b1, 5'd0, 5'd0, 5'd5, 4'd3);
    set_iss(1, 1'b1, 5'd5, 5'd0, 5'd0, 4'd0);
    #1;
    checks++; if (src1_dep[1] !== 1'b1) begin errors++; $display("FAIL grp_dep got %b want 1", src1_dep[1]); end
    checks++; if (src1_rob[7:4] !== 4'd3) begin errors++; $display("FAIL grp_rob got %0d want 3", src1_rob[7:4]); end
    tick();
    checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL grp_busy_cnt got %0d want 1", busy_cnt); end
    checks++; if (dut.r_qi[5] !== 4'd3) begin errors++; $display("FAIL grp_qi5 got %0d want 3", dut.r_qi[5]); end
    idle();
    set_iss(0, 1'b0, 5'd5, 5'd0, 5'd0, 4'd0);
    #1;
    checks++; if (src1_dep[0] !== 1'b1 || src1_rob[3:0] !== 4'd3) begin errors++; $display("FAIL wait_tag got dep=%b rob=%0d want dep=1 rob=3", src1_dep[0], src1_rob[3:0]); end
    checks++; if (q1_id[3:0] !== 4'd3) begin errors++; $display("FAIL q1_id got %0d want 3", q1_id[3:0]); end
    q1_ready[0] = 1'b1; q1_val[31:0] = 32'h1234;
    #1;
    checks++; if (src1_dep[0] !== 1'b0 || src1_val[31:0] !== 32'h1234) begin errors++; $display("FAIL rob_bypass got dep=%b val=%h want dep=0 val=1234", src1_dep[0], src1_val[31:0]); end
  endtask

  task automatic test_commit_bypass();
    idle();
    set_iss(0, 1'b1, 5'd0, 5'd5, 5'd0, 4'd0);
    set_cmt(0, 1'b1, 5'd5, 4'd3, 32'hDEAD);
    q2_ready[0] = 1'b1; q2_val[31:0] = 32'hBEEF;
    #1;
    checks++; if (src2_dep[0] !== 1'b0 || src2_val[31:0] !== 32'hDEAD) begin errors++; $display("FAIL cmt_bypass got dep=%b val=%h want dep=0 val=dead", src2_dep[0], src2_val[31:0]); end
    tick();
    checks++; if (dut.r_busy[5] !== 1'b0) begin errors++; $display("FAIL cmt_busy5 got %b want 0", dut.r_busy[5]); end
    checks++; if (dut.r_regs[5] !== 32'hDEAD) begin errors++; $display("FAIL cmt_regs5 got %h want dead", dut.r_regs[5]); end
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL cmt_busy_cnt got %0d want 0", busy_cnt); end
  endtask

  task automatic test_commit_vs_issue();
    idle();
    set_iss(0, 1'b1, 5'd0, 5'd0, 5'd7, 4'd2);
    tick();
    idle();
    set_iss(1, 1'b1, 5'd0, 5'd0, 5'd7, 4'd6);
    set_cmt(0, 1'b1, 5'd7, 4'd2, 32'h777);
    tick();
    checks++; if (dut.r_regs[7] !== 32'h777) begin errors++; $display("FAIL cvi_regs7 got %h want 777", dut.r_regs[7]); end
    checks++; if (dut.r_qi[7] !== 4'd6 || dut.r_busy[7] !== 1'b1) begin errors++; $display("FAIL cvi_qi7 got qi=%0d busy=%b want qi=6 busy=1", dut.r_qi[7], dut.r_busy[7]); end
    idle();
    set_cmt(0, 1'b1, 5'd7, 4'd2, 32'h888);
    tick();
    checks++; if (dut.r_regs[7] !== 32'h888 || dut.r_busy[7] !== 1'b1) begin errors++; $display("FAIL stale_cmt got regs=%h busy=%b want regs=888 busy=1", dut.r_regs[7], dut.r_busy[7]); end
  endtask

  task automatic test_same_rd();
    idle();
    set_cmt(0, 1'b1, 5'd9, 4'd10, 32'd1);
    set_cmt(1, 1'b1, 5'd9, 4'd11, 32'd2);
    set_iss(0, 1'b1, 5'd0, 5'd0, 5'd0, 4'd5);
    tick();
    checks++; if (dut.r_regs[9] !== 32'd2) begin errors++; $display("FAIL same_rd_regs9 got %0d want 2", dut.r_regs[9]); end
    checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL rd0_busy_cnt got %0d want 1", busy_cnt); end
    idle();
    set_iss(0, 1'b1, 5'd9, 5'd0, 5'd10, 4'd1);
    set_iss(1, 1'b1, 5'd0, 5'd0, 5'd10, 4'd4);
    #1;
    checks++; if (src1_val[31:0] !== 32'd2 || src1_dep[0] !== 1'b0) begin errors++; $display("FAIL reg_read9 got val=%h dep=%b want val=2 dep=0", src1_val[31:0], src1_dep[0]); end
    tick();
    checks++; if (dut.r_qi[10] !== 4'd4) begin errors++; $display("FAIL young_issue_qi10 got %0d want 4", dut.r_qi[10]); end
    checks++; if (busy_cnt !== 6'd2) begin errors++; $display("FAIL issue_busy_cnt got %0d want 2", busy_cnt); end
  endtask

  task automatic test_clear();
    idle();
    set_iss(0, 1'b1, 5'd0, 5'd0, 5'd4, 4'd7);
    set_iss(1, 1'b1, 5'd0, 5'd0, 5'd11, 4'd8);
    tick();
    checks++; if (busy_cnt !== 6'd4) begin errors++; $display("FAIL pre_clear_busy_cnt got %0d want 4", busy_cnt); end
    idle();
    clear_flag = 1'b1;
    set_cmt(0, 1'b1, 5'd4, 4'd0, 32'h55);
    set_iss(0, 1'b1, 5'd0, 5'd0, 5'd8, 4'd9);
    tick();
    checks++; if (dut.r_regs[4] !== 32'h55) begin errors++; $display("FAIL clear_regs4 got %h want 55", dut.r_regs[4]); end
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL clear_busy_cnt got %0d want 0", busy_cnt); end
    checks++; if (dut.r_busy !== 32'h0) begin errors++; $display("FAIL clear_busy got %h want 0", dut.r_busy); end
  endtask

  task automatic test_stall();
    idle();
    rdy_in = 1'b0;
    set_iss(0, 1'b1, 5'd4, 5'd0, 5'd12, 4'd1);
    set_iss(1, 1'b1, 5'd12, 5'd0, 5'd0, 4'd0);
    set_cmt(0, 1'b1, 5'd13, 4'd0, 32'h99);
    #1;
    checks++; if (src1_val[31:0] !== 32'h55 || src1_dep[0] !== 1'b0) begin errors++; $display("FAIL stall_comb_val got val=%h dep=%b want val=55 dep=0", src1_val[31:0], src1_dep[0]); end
    checks++; if (src1_dep[1] !== 1'b1 || src1_rob[7:4] !== 4'd1) begin errors++; $display("FAIL stall_comb_grp got dep=%b rob=%0d want dep=1 rob=1", src1_dep[1], src1_rob[7:4]); end
    tick();
    checks++; if (dut.r_busy[12] !== 1'b0 || busy_cnt !== 6'd0) begin errors++; $display("FAIL stall_busy got busy12=%b cnt=%0d want 0 0", dut.r_busy[12], busy_cnt); end
    checks++; if (dut.r_regs[13] !== 32'h0) begin errors++; $display("FAIL stall_regs13 got %h want 0", dut.r_regs[13]); end
    rdy_in = 1'b1;
  endtask

  task automatic test_reset_midrun();
    idle();
    set_iss(0, 1'b1, 5'd0, 5'd0, 5'd1, 4'd2);
    set_iss(1, 1'b1, 5'd0, 5'd0, 5'd2, 4'd3);
    tick();
    idle();
    set_iss(0, 1'b0, 5'd1, 5'd2, 5'd0, 4'd0);
    set_iss(1, 1'b0, 5'd5, 5'd0, 5'd0, 4'd0);
    #1;
    checks++; if (busy_cnt !== 6'd2 || src1_dep[0] !== 1'b1) begin errors++; $display("FAIL pre_rst got cnt=%0d dep=%b want cnt=2 dep=1", busy_cnt, src1_dep[0]); end
    #2 rst_in = 1'b0;
    #1;
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL async_rst_cnt got %0d want 0", busy_cnt); end
    checks++; if (src1_dep[0] !== 1'b0 || src2_dep[0] !== 1'b0) begin errors++; $display("FAIL async_rst_dep got %b %b want 0 0", src1_dep[0], src2_dep[0]); end
    checks++; if (src1_val[31:0] !== 32'h0 || src1_val[63:32] !== 32'h0) begin errors++; $display("FAIL async_rst_val got %h %h want 0 0", src1_val[31:0], src1_val[63:32]); end
    #2 rst_in = 1'b1;
  endtask

  initial begin
    rst_in = 1'b0;
    rdy_in = 1'b1;
    idle();
    #12 rst_in = 1'b1;
    test_reset();
    test_group_rename();
    test_commit_bypass();
    test_commit_vs_issue();
    test_same_rd();
    test_clear();
    test_stall();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
